// File: rtl/par_ser_stream.sv
// Parallel-to-serial converter with a one-word holding register ahead of the shifter,
// so back-to-back words leave with no idle bit between them.
//
// state | meaning
// IDLE  | shifter empty, ser_out parked at IDLE_VAL
// SHIFT | shifter transmitting bit cnt of the current word
module par_ser_stream #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_VAL  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] hr;
    logic [CW-1:0]    cnt;
    logic             hold_full;
    logic             accept;
    logic             load;

    assign in_ready = ~hold_full & ~reset;
    assign accept   = in_valid & in_ready;
    // Reloading on the last bit is what keeps consecutive words gap-free.
    assign load     = enb & hold_full & ((state == IDLE) | (cnt == LAST));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sr        <= '0;
            hr        <= '0;
            cnt       <= '0;
            hold_full <= 1'b0;
        end else begin
            if (accept) begin
                hr        <= in_data;
                hold_full <= 1'b1;
            end
            if (load) begin
                sr    <= hr;
                cnt   <= '0;
                state <= SHIFT;
                if (!accept)
                    hold_full <= 1'b0;
            end else if (enb && state == SHIFT) begin
                if (cnt != LAST) begin
                    cnt <= cnt + CW'(1);
                    sr  <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

    assign ser_valid   = (state == SHIFT);
    assign ser_out     = (state == SHIFT) ? (MSB_FIRST ? sr[WIDTH-1] : sr[0]) : IDLE_VAL;
    assign frame_start = (state == SHIFT) && (cnt == '0);
    assign busy        = (state == SHIFT) | hold_full;

endmodule

// File: tb/tb_par_ser_stream.sv
// Scoreboard bench: four serializer variants (8 MSB, 8 LSB, 2 MSB, 16 MSB) share clk/reset/enb;
// send() queues expected {frame_start, bit} pairs and a negedge monitor pops and compares them.
module tb_par_ser_stream;

    logic clk = 1'b0;
    logic reset;
    logic enb;
    logic iv [4];
    logic rdy [4];
    logic so [4];
    logic sv [4];
    logic fs [4];
    logic bz [4];
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [1:0]  d2;
    logic [15:0] d3;

    int vectors = 0;
    int errors  = 0;
    logic enb_q = 1'b1;
    logic prev_v [4];
    logic [1:0] last_e [4];
    logic [1:0] q0 [$];
    logic [1:0] q1 [$];
    logic [1:0] q2 [$];
    logic [1:0] q3 [$];

    always #5 clk = ~clk;

    par_ser_stream #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_VAL(1'b0)) u0 (
        .clk(clk), .reset(reset), .enb(enb), .in_valid(iv[0]), .in_data(d0), .in_ready(rdy[0]),
        .ser_out(so[0]), .ser_valid(sv[0]), .frame_start(fs[0]), .busy(bz[0]));
    par_ser_stream #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_VAL(1'b0)) u1 (
        .clk(clk), .reset(reset), .enb(enb), .in_valid(iv[1]), .in_data(d1), .in_ready(rdy[1]),
        .ser_out(so[1]), .ser_valid(sv[1]), .frame_start(fs[1]), .busy(bz[1]));
    par_ser_stream #(.WIDTH(2), .MSB_FIRST(1'b1), .IDLE_VAL(1'b0)) u2 (
        .clk(clk), .reset(reset), .enb(enb), .in_valid(iv[2]), .in_data(d2), .in_ready(rdy[2]),
        .ser_out(so[2]), .ser_valid(sv[2]), .frame_start(fs[2]), .busy(bz[2]));
    par_ser_stream #(.WIDTH(16), .MSB_FIRST(1'b1), .IDLE_VAL(1'b0)) u3 (
        .clk(clk), .reset(reset), .enb(enb), .in_valid(iv[3]), .in_data(d3), .in_ready(rdy[3]),
        .ser_out(so[3]), .ser_valid(sv[3]), .frame_start(fs[3]), .busy(bz[3]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // enb as seen by the last rising edge; tells the monitor whether the shifter could advance
    always @(posedge clk) enb_q <= enb;

    always @(negedge clk) begin
        int qs;
        logic [1:0] e;
        for (int d = 0; d < 4; d++) begin
            case (d)
                0: qs = q0.size();
                1: qs = q1.size();
                2: qs = q2.size();
                default: qs = q3.size();
            endcase
            if (sv[d]) begin
                if (enb_q) begin
                    if (qs == 0) begin
                        chk($sformatf("stray_bit_dut%0d", d), 32'd1, 32'd0);
                    end else begin
                        case (d)
                            0: e = q0.pop_front();
                            1: e = q1.pop_front();
                            2: e = q2.pop_front();
                            default: e = q3.pop_front();
                        endcase
                        last_e[d] = e;
                        chk($sformatf("bit_dut%0d", d), {30'd0, fs[d], so[d]}, {30'd0, e});
                    end
                end else begin
                    chk($sformatf("stall_hold_dut%0d", d), {30'd0, fs[d], so[d]}, {30'd0, last_e[d]});
                end
            end else begin
                if (prev_v[d] && enb_q && qs > 0)
                    chk($sformatf("gap_dut%0d", d), 32'd0, 32'd1);
                chk($sformatf("idle_out_dut%0d", d), {30'd0, fs[d], so[d]}, 32'd0);
            end
            prev_v[d] = sv[d];
        end
    end

    task automatic send(input int d, input logic [15:0] data);
        int w;
        bit msb;
        int guard;
        int idx;
        case (d)
            0: begin w = 8;  msb = 1'b1; d0 = data[7:0]; end
            1: begin w = 8;  msb = 1'b0; d1 = data[7:0]; end
            2: begin w = 2;  msb = 1'b1; d2 = data[1:0]; end
            default: begin w = 16; msb = 1'b1; d3 = data; end
        endcase
        iv[d] = 1'b1;
        guard = 0;
        while (!rdy[d] && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 100) begin
            chk($sformatf("accept_timeout_dut%0d", d), 32'd0, 32'd1);
            iv[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
        for (int i = 0; i < w; i++) begin
            idx = msb ? (w - 1 - i) : i;
            case (d)
                0: q0.push_back({i == 0, data[idx]});
                1: q1.push_back({i == 0, data[idx]});
                2: q2.push_back({i == 0, data[idx]});
                default: q3.push_back({i == 0, data[idx]});
            endcase
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((bz[0] || bz[1] || bz[2] || bz[3] || q0.size() > 0 || q1.size() > 0 ||
                q2.size() > 0 || q3.size() > 0) && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 300)
            chk("idle_timeout", 32'd0, 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        enb   = 1'b1;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        for (int d = 0; d < 4; d++) begin
            iv[d] = 1'b0;
            prev_v[d] = 1'b0;
            last_e[d] = 2'b00;
        end
        #3;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_ready_dut%0d", d), {31'd0, rdy[d]}, 32'd0);
            chk($sformatf("rst_valid_dut%0d", d), {31'd0, sv[d]}, 32'd0);
            chk($sformatf("rst_busy_dut%0d", d), {31'd0, bz[d]}, 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        for (int d = 0; d < 4; d++)
            chk($sformatf("post_rst_ready_dut%0d", d), {31'd0, rdy[d]}, 32'd1);

        // single word, MSB first and LSB first
        send(0, 16'h00B4);
        chk("busy_after_accept", {31'd0, bz[0]}, 32'd1);
        wait_idle();
        send(1, 16'h00B4);
        wait_idle();

        // back-to-back 0xFF then 0x00
        send(0, 16'h00FF);
        send(0, 16'h0000);
        chk("b2b_ready_low", {31'd0, rdy[0]}, 32'd0);
        chk("b2b_busy", {31'd0, bz[0]}, 32'd1);
        wait_idle();

        // enb stall after bit 2, with an accept during the stall
        send(0, 16'h00B4);
        repeat (3) @(posedge clk);
        #1 enb = 1'b0;
        send(0, 16'h005A);
        chk("stall_accept_ready_low", {31'd0, rdy[0]}, 32'd0);
        repeat (4) @(posedge clk);
        #1 enb = 1'b1;
        wait_idle();

        // reset mid-word after three bits
        send(0, 16'h00B4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, sv[0]}, 32'd0);
        chk("midrst_out", {31'd0, so[0]}, 32'd0);
        chk("midrst_ready", {31'd0, rdy[0]}, 32'd0);
        chk("midrst_busy", {31'd0, bz[0]}, 32'd0);
        q0.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midrst_ready_release", {31'd0, rdy[0]}, 32'd1);
        repeat (12) @(posedge clk);
        #1;

        // width sweep
        send(2, 16'h0002);
        wait_idle();
        send(3, 16'h8001);
        wait_idle();
        send(2, 16'h0001);
        send(2, 16'h0003);
        wait_idle();

        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        chk("q2_drained", q2.size(), 32'd0);
        chk("q3_drained", q3.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
